// File: rtl/mcode_seq_if.sv
// Bundle of sequencer-facing signals: start/entry control, ROM bus and datapath controls.
// Vectors are MSB-first; the legacy bit 0 of each field is the MSB here.
interface mcode_seq_if;
    logic        start;
    logic [5:0]  entry;
    logic [3:0]  cond;
    logic [26:0] z;
    logic [5:0]  a;
    logic        mclk;
    logic [8:0]  ctl;
    logic        ctl_vld;
    logic        busy;
    logic        err;

    modport master (
        input  start, entry, cond, z,
        output a, mclk, ctl, ctl_vld, busy, err
    );

    modport slave (
        output start, entry, cond, z,
        input  a, mclk, ctl, ctl_vld, busy, err
    );
endinterface

// File: rtl/mcode_seq.sv
// Microprogram sequencer: drives the microcode ROM address/strobe, decodes the
// returned microword and computes the next address (branch, call/return, loop).
module mcode_seq #(
    parameter int unsigned STK_DEPTH = 4
) (
    input logic         sys_clk,
    input logic         resetl,
    mcode_seq_if.master bus
);
    localparam int unsigned SPW = $clog2(STK_DEPTH) + 1;
    localparam int unsigned IXW = SPW - 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_STRB = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_EXEC = 3'd4;

    localparam logic [2:0] OP_CONT  = 3'd0;
    localparam logic [2:0] OP_JMP   = 3'd1;
    localparam logic [2:0] OP_JCC   = 3'd2;
    localparam logic [2:0] OP_CALL  = 3'd3;
    localparam logic [2:0] OP_RET   = 3'd4;
    localparam logic [2:0] OP_LDCNT = 3'd5;
    localparam logic [2:0] OP_LOOP  = 3'd6;
    localparam logic [2:0] OP_HALT  = 3'd7;

    logic [2:0]     state;
    logic [5:0]     a_q;
    logic           mclk_q;
    logic [8:0]     ctl_q;
    logic           ctl_vld_q;
    logic           err_q;
    logic [SPW-1:0] sp;
    logic [5:0]     cnt;
    logic [5:0]     stk [STK_DEPTH];

    logic [5:0]     f_tgt;
    logic [2:0]     f_op;
    logic [1:0]     f_sel;
    logic           f_pol;
    logic [5:0]     f_cnt;
    logic [8:0]     f_ctl;

    logic [5:0]     pc_inc;
    logic [SPW-1:0] sp_dec;
    logic [IXW-1:0] push_ix;
    logic [IXW-1:0] pop_ix;
    logic           stk_full;
    logic           stk_empty;
    logic           cond_hit;

    logic [5:0]     nxt_a;
    logic [SPW-1:0] nxt_sp;
    logic [5:0]     nxt_cnt;
    logic           ex_err;
    logic           ex_halt;
    logic           do_push;

    assign f_tgt = bus.z[26:21];
    assign f_op  = bus.z[20:18];
    assign f_sel = bus.z[17:16];
    assign f_pol = bus.z[15];
    assign f_cnt = bus.z[14:9];
    assign f_ctl = bus.z[8:0];

    assign pc_inc    = a_q + 6'd1;
    assign sp_dec    = sp - SPW'(1);
    assign push_ix   = sp[IXW-1:0];
    assign pop_ix    = sp_dec[IXW-1:0];
    assign stk_full  = (sp == SPW'(STK_DEPTH));
    assign stk_empty = (sp == '0);
    // Legacy flag cond[0] is the MSB, so flag n sits at bit 3-n.
    assign cond_hit  = bus.cond[2'd3 - f_sel] ^ f_pol;

    always_comb begin
        nxt_a   = pc_inc;
        nxt_sp  = sp;
        nxt_cnt = cnt;
        ex_err  = 1'b0;
        ex_halt = 1'b0;
        do_push = 1'b0;
        case (f_op)
            OP_CONT: ;
            OP_JMP:  nxt_a = f_tgt;
            OP_JCC:  if (cond_hit) nxt_a = f_tgt;
            OP_CALL: begin
                if (stk_full) begin
                    ex_err = 1'b1;
                    nxt_a  = a_q;
                end else begin
                    do_push = 1'b1;
                    nxt_sp  = sp + SPW'(1);
                    nxt_a   = f_tgt;
                end
            end
            OP_RET: begin
                if (stk_empty) begin
                    ex_err = 1'b1;
                    nxt_a  = a_q;
                end else begin
                    nxt_sp = sp_dec;
                    nxt_a  = stk[pop_ix];
                end
            end
            OP_LDCNT: nxt_cnt = f_cnt;
            OP_LOOP: begin
                if (cnt != '0) begin
                    nxt_cnt = cnt - 6'd1;
                    nxt_a   = f_tgt;
                end
            end
            OP_HALT: begin
                ex_halt = 1'b1;
                nxt_a   = a_q;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            state     <= S_IDLE;
            a_q       <= '0;
            mclk_q    <= 1'b0;
            ctl_q     <= '0;
            ctl_vld_q <= 1'b0;
            err_q     <= 1'b0;
            sp        <= '0;
            cnt       <= '0;
        end else begin
            ctl_vld_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    mclk_q <= 1'b0;
                    if (bus.start) begin
                        a_q   <= bus.entry;
                        err_q <= 1'b0;
                        sp    <= '0;
                        cnt   <= '0;
                        state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    mclk_q <= 1'b0;
                    state  <= S_STRB;
                end
                S_STRB: begin
                    mclk_q <= 1'b1;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    mclk_q <= 1'b1;
                    state  <= S_EXEC;
                end
                S_EXEC: begin
                    mclk_q    <= 1'b0;
                    ctl_q     <= f_ctl;
                    ctl_vld_q <= 1'b1;
                    a_q       <= nxt_a;
                    sp        <= nxt_sp;
                    cnt       <= nxt_cnt;
                    if (ex_err) err_q <= 1'b1;
                    state     <= (ex_err || ex_halt) ? S_IDLE : S_ADDR;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (state == S_EXEC && do_push) stk[push_ix] <= pc_inc;
    end

    assign bus.a       = a_q;
    assign bus.mclk    = mclk_q;
    assign bus.ctl     = ctl_q;
    assign bus.ctl_vld = ctl_vld_q;
    assign bus.err     = err_q;
    assign bus.busy    = (state != S_IDLE);
endmodule

// File: doc/mcode_seq.md
# mcode_seq

Microprogram sequencer that sits directly upstream of the 64×27 microcode ROM. It generates the ROM's 6-bit address and its sampling strobe, then decodes the returned 27-bit microword. From that word it produces the next address using branch, call/return and loop logic, and it emits the word's control field to the datapath. It runs entirely on `sys_clk`; the ROM strobe it drives is a level that the ROM edge-detects in the same clock domain.

## Interface
Parameters:
- `STK_DEPTH`, 4: return-stack depth. Power of two, 2..8.

Ports:
- `sys_clk`  in  1: system clock; all state changes on its rising edge.
- `resetl`  in  1: asynchronous, active-low reset.
- `start`  in  1: begin execution at `entry`; sampled only in IDLE.
- `entry`  in  [0:5]: start address.
- `cond`  in  [0:3]: datapath condition flags.
- `z`  in  [0:26]: microword from the ROM.
- `a`  out  [0:5]: ROM address (registered).
- `mclk`  out  1: ROM sample strobe (registered).
- `ctl`  out  [0:8]: control field, equal to `z[18:26]`, registered in EXEC.
- `ctl_vld`  out  1: one-cycle pulse when `ctl` is new.
- `busy`  out  1: high in every state except IDLE.
- `err`  out  1: sticky error flag (stack overflow or underflow); cleared by `start`.

## Operation
Microword fields:
- `z[0:5]`: target address.
- `z[6:8]`: op.
- `z[9:10]`: condition select.
- `z[11]`: condition polarity (1 = branch when the flag is low).
- `z[12:17]`: loop count.
- `z[18:26]`: ctl.

Ops (`pc` denotes the current `a`):
- 0 CONT: next address is pc+1.
- 1 JMP: next address is the target.
- 2 JCC: if `cond[sel]` XOR `pol` is true, go to the target; otherwise pc+1.
- 3 CALL: push pc+1, go to the target. If the stack is full, set `err` and go to IDLE.
- 4 RET: pop and go to the popped address. If the stack is empty, set `err` and go to IDLE.
- 5 LDCNT: `cnt` ← `z[12:17]`, then pc+1.
- 6 LOOP: if `cnt` ≠ 0, `cnt` ← `cnt`−1 and go to the target; otherwise pc+1.
- 7 HALT: go to IDLE; `a` holds its value.

Arithmetic and width rules:
- pc+1 is modulo 64, so 63 wraps to 0.
- `cnt` is 6 bits and never goes negative.

State machine:
- IDLE: `mclk` = 0. On `start`, `a` ← `entry`, `err` ← 0, stack pointer ← 0, `cnt` ← 0, then go to ADDR.
- ADDR: `mclk` = 0. This guarantees a low phase before the ROM's edge detector sees the strobe. Go to STRB.
- STRB: `mclk` = 1. The ROM loads `z` on the next edge. Go to WAIT.
- WAIT: `mclk` = 1. `z` becomes valid at the end of this cycle. Go to EXEC.
- EXEC:
  - `mclk` ← 0.
  - `ctl` ← `z[18:26]` and `ctl_vld` pulses, for every op including HALT.
  - The op executes and `a` ← next address.
  - Go to ADDR, or to IDLE on HALT or on an error.
  - On an error, `ctl` is still emitted but no push or pop happens.

Reset behaviour: all outputs are 0 during reset, and the state is IDLE, stack pointer 0, `cnt` 0.

## Timing
- One microinstruction takes exactly 4 `sys_clk` cycles (ADDR, STRB, WAIT, EXEC).
- `start` sampled at edge N:
  - `a` = `entry` after edge N.
  - `mclk` rises after edge N+2.
  - `ctl_vld` is high in the cycle after edge N+4.
- Each following instruction's `ctl_vld` comes 4 cycles after the previous one.
- `start` while busy is ignored.
- `ctl` holds its value between pulses.
- `busy` drops in the cycle following the EXEC of a HALT or of an error.
- `cond` is sampled only in EXEC.
- Reset asserted mid-instruction forces IDLE and zeros all outputs immediately (asynchronously). After release, the sequencer stays in IDLE until the next `start`.
- CALL and RET in back-to-back instructions are legal. The stack pointer updates in EXEC.

## Test plan
- Linear run: ROM[0..2] = CONT, CONT, HALT; `start` with `entry` = 0 → `a` sequence 0, 1, 2; three `ctl_vld` pulses spaced 4 cycles apart; `busy` low 13 cycles after `start`.
- Branch: `cond` = 4'b0100; JCC with sel = 1, pol = 0, target 0x20 → next `a` = 0x20. Repeat with pol = 1 → next `a` = pc+1.
- Call/return: CALL to 0x10 from pc 5; RET at 0x10 → `a` sequence 5, 0x10, 6. Five nested CALLs with `STK_DEPTH` = 4 → `err` = 1, return to IDLE. RET on an empty stack → `err` = 1.
- Loop: LDCNT 3 at pc 8; LOOP at pc 9 with target 9 → instruction at pc 9 executes 4 times, then `a` = 10.
- Wrap: CONT at 63 → next `a` = 0.
- Reset mid-run: assert `resetl` low during WAIT → `a`, `mclk`, `ctl`, `busy`, `err` = 0 at once; after release, no activity until `start`.
